ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port synchronous RAM between two requesters: port A (CPU)
// and port B (DMA/video). It grants one request per cycle, alternating between
// A and B when both request. The granted command is registered onto the RAM
// pins. Each granted read is tracked with a short tag pipeline, so the RAM read
// data is returned to the port that issued the read.
//
// Timing, relative to a grant in cycle N:
//   N    aGnt/bGnt asserted (combinational)
//   N+1  command visible on ramWEn/ramAddr/ramDataIn
//   N+2  ramDataOut carries the read word
//   N+3  xValid pulses for one cycle; xDataOut holds the word until the next
//        read return to the same port
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   aReq/aWEn/aAddr/aDataIn           port A request (write when aWEn=1)
//   aGnt/aValid/aDataOut              port A grant, read strobe, read data
//   bReq/bWEn/bAddr/bDataIn           port B request
//   bGnt/bValid/bDataOut              port B grant, read strobe, read data
//   ramWEn/ramAddr/ramDataIn          registered RAM command
//   ramDataOut                        RAM read data (one cycle after command)
// ----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic                     aReq,
  input  logic                     aWEn,
  input  logic [ADDRESS_WIDTH-1:0] aAddr,
  input  logic [DATA_WIDTH-1:0]    aDataIn,
  output logic                     aGnt,
  output logic                     aValid,
  output logic [DATA_WIDTH-1:0]    aDataOut,

  input  logic                     bReq,
  input  logic                     bWEn,
  input  logic [ADDRESS_WIDTH-1:0] bAddr,
  input  logic [DATA_WIDTH-1:0]    bDataIn,
  output logic                     bGnt,
  output logic                     bValid,
  output logic [DATA_WIDTH-1:0]    bDataOut,

  output logic                     ramWEn,
  output logic [ADDRESS_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0]    ramDataIn,
  input  logic [DATA_WIDTH-1:0]    ramDataOut
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // One entry of the read-return pipeline: is a read in flight, and for whom.
  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  port_e                     last_grant;
  tag_t                      tag_s1;
  tag_t                      tag_s2;

  logic                      any_gnt;
  port_e                     sel_port;
  logic                      sel_wen;
  logic [ADDRESS_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;

  // Grant decision. A wins unless B also requests and A was granted last.
  // Grants are held low during reset, so no command is accepted until
  // reset_n rises.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves a signal unassigned and infers a latch.
    aGnt = 1'b0;
    bGnt = 1'b0;
    if (reset_n) begin
      if (aReq && (!bReq || last_grant == PORT_B)) begin
        aGnt = 1'b1;
      end else if (bReq) begin
        bGnt = 1'b1;
      end
    end
  end

  assign any_gnt  = aGnt | bGnt;
  assign sel_port = bGnt ? PORT_B : PORT_A;
  assign sel_wen  = bGnt ? bWEn    : aWEn;
  assign sel_addr = bGnt ? bAddr   : aAddr;
  assign sel_data = bGnt ? bDataIn : aDataIn;

  // Command register, arbitration history and read-return pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // B counts as the last winner, so A wins the first conflict.
      last_grant <= PORT_B;
      ramWEn     <= 1'b0;
      ramAddr    <= '0;
      ramDataIn  <= '0;
      tag_s1     <= '0;
      tag_s2     <= '0;
      aValid     <= 1'b0;
      bValid     <= 1'b0;
      aDataOut   <= '0;
      bDataOut   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the clock edge, whatever the
      // statement order.
      ramWEn <= any_gnt && sel_wen;
      // On idle cycles the address and data pins keep their previous values.
      if (any_gnt) begin
        ramAddr    <= sel_addr;
        ramDataIn  <= sel_data;
        last_grant <= sel_port;
      end

      // Tag stage 1 lines up with the command on the RAM pins.
      // Stage 2 lines up with the data on ramDataOut.
      tag_s1 <= '{valid: any_gnt && !sel_wen, port: sel_port};
      tag_s2 <= tag_s1;

      aValid <= tag_s2.valid && (tag_s2.port == PORT_A);
      bValid <= tag_s2.valid && (tag_s2.port == PORT_B);
      if (tag_s2.valid && tag_s2.port == PORT_A) begin
        aDataOut <= ramDataOut;
      end
      if (tag_s2.valid && tag_s2.port == PORT_B) begin
        bDataOut <= ramDataOut;
      end
    end
  end

endmodule
